// File: rtl/clk_rst_gen.sv
// Clock divider and staggered reset sequencer for the SGBM pipeline.
// Every channel has its own programmable divisor; domain resets are released in ascending order.
module clk_rst_gen #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 8,
  parameter int DIV_INIT  = 4,
  parameter int RST_DLY   = 200,
  parameter int STAGE_GAP = 16
) (
  input  logic                    clkin,
  input  logic                    restn,
  input  logic                    soft_rst,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       rst_out_n,
  output logic                    ready
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);
  localparam int DLY_W = $clog2(RST_DLY) + 1;
  localparam int GAP_W = $clog2(STAGE_GAP) + 1;
  localparam int K_W   = $clog2(NUM_CH) + 1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic [DIV_W-1:0] neff, half;
    logic             clk_q, clk_d;
    logic             ce_q, ce_d;
    logic             wrap;

    // The active divisor only changes on the wrap edge, so a period is never cut short.
    always_comb begin
      neff  = (act_q < DIV_W'(2)) ? DIV_W'(2) : act_q;
      half  = neff >> 1;
      wrap  = (cnt_q == neff - DIV_W'(1));
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      act_d = wrap ? shd_q : act_q;
      shd_d = div_load[g] ? div_val[g*DIV_W +: DIV_W] : shd_q;
      clk_d = (cnt_q < half);
      ce_d  = (cnt_q == '0);
    end

    always_ff @(posedge clkin or negedge restn) begin
      if (!restn) begin
        cnt_q <= '0;
        act_q <= DIV_RST;
        shd_q <= DIV_RST;
        clk_q <= 1'b0;
        ce_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        act_q <= act_d;
        shd_q <= shd_d;
        clk_q <= clk_d;
        ce_q  <= ce_d;
      end
    end

    assign clk_div[g] = clk_q;
    assign ce[g]      = ce_q;
  end

  typedef enum logic [1:0] {S_RESET, S_WAIT, S_RELEASE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [NUM_CH-1:0] rstn_q, rstn_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    gap_d   = gap_q;
    k_d     = k_q;
    rstn_d  = rstn_q;
    ready_d = 1'b0;
    if (soft_rst) begin
      state_d = S_RESET;
      dly_d   = '0;
      gap_d   = '0;
      k_d     = '0;
      rstn_d  = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_d = S_WAIT;
          dly_d   = '0;
          rstn_d  = '0;
        end
        S_WAIT: begin
          if (dly_q == DLY_W'(RST_DLY - 1)) begin
            rstn_d[0] = 1'b1;
            gap_d     = '0;
            k_d       = '0;
            state_d   = (NUM_CH == 1) ? S_RUN : S_RELEASE;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
        S_RELEASE: begin
          if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
            gap_d = '0;
            k_d   = k_q + K_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
              if (k_q + K_W'(1) == K_W'(i)) rstn_d[i] = 1'b1;
            end
            if (k_q + K_W'(1) == K_W'(NUM_CH - 1)) state_d = S_RUN;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        S_RUN: ready_d = 1'b1;
        default: state_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge restn) begin
    if (!restn) begin
      state_q <= S_RESET;
      dly_q   <= '0;
      gap_q   <= '0;
      k_q     <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      gap_q   <= gap_d;
      k_q     <= k_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
    end
  end

  assign rst_out_n = rstn_q;
  assign ready     = ready_q;

endmodule
